// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte sources,
// with a watchdog that releases the transmitter if its sent flag never rises.
module uart_tx_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  input  logic                     tx_sent,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     timeout_err
);

  localparam int unsigned GW  = $clog2(NREQ);
  localparam int unsigned TW  = $clog2(TIMEOUT) + 1;
  localparam int unsigned GCW = $clog2(GAP_CYCLES + 1) + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t          state_q, state_d;
  logic            sent_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GCW-1:0]  gap_q, gap_d;
  logic [NREQ-1:0] req_ready_d;
  logic            tx_en_d, busy_d, timeout_d;
  logic [7:0]      tx_data_d;
  logic [GW-1:0]   grant_d;

  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic            sent_edge;
  int unsigned     idx;

  assign sent_edge = tx_sent & ~sent_q;

  // Round-robin search starting just above the last grant, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = 32'(grant_id) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req_valid[GW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    req_ready_d = '0;
    tx_en_d     = 1'b0;
    timeout_d   = 1'b0;
    tx_data_d   = tx_data;
    grant_d     = grant_id;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d              = START;
          grant_d              = win_idx;
          tx_data_d            = req_data[{win_idx, 3'b000} +: 8];
          req_ready_d[win_idx] = 1'b1;
          tx_en_d              = 1'b1;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (sent_edge || timer_q == TW'(TIMEOUT - 1)) begin
          timeout_d = ~sent_edge;
          gap_d     = '0;
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GCW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                gap_d   = gap_q + GCW'(1);
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sent_q      <= 1'b0;
      timer_q     <= '0;
      gap_q       <= '0;
      req_ready   <= '0;
      tx_en       <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      grant_id    <= GW'(NREQ - 1);
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      sent_q      <= tx_sent;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      req_ready   <= req_ready_d;
      tx_en       <= tx_en_d;
      tx_data     <= tx_data_d;
      busy        <= busy_d;
      grant_id    <= grant_d;
      timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed grants queue their expected
// (requester, byte) pairs; a negedge monitor checks each tx_en start pulse.
module tb_uart_tx_arbiter;
  localparam int unsigned NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              tx_sent;
  logic              busy;
  logic [1:0]        grant_id;
  logic              timeout_err;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(16), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_sent(tx_sent),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   to_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every start pulse must match the oldest expected grant.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL grant_unexpected: id=%0d data=%02h but no grant expected", grant_id, tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (grant_id !== mon_e.id || tx_data !== mon_e.data || req_ready !== (4'b0001 << mon_e.id)) begin
            failures++;
            $display("FAIL grant: got id=%0d data=%02h ready=%b expected id=%0d data=%02h ready=%b",
                     grant_id, tx_data, req_ready, mon_e.id, mon_e.data, 4'b0001 << mon_e.id);
          end
        end
      end else if (req_ready != '0) begin
        checks++;
        failures++;
        $display("FAIL ready_without_start: got ready=%b expected 0000", req_ready);
      end
      if (timeout_err) to_pulses++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input int i, input logic [7:0] d);
    req_valid[i]        = 1'b1;
    req_data[8*i +: 8]  = d;
    exp_q.push_back('{id: 2'(i), data: d});
  endtask

  task automatic wait_tx_en(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = tx_en;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s: got no tx_en within 40 cycles expected a start pulse", name);
    end
  endtask

  task automatic complete(input int delay);
    cyc(delay);
    tx_sent = 1'b1;
    cyc(1);
    tx_sent = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; tx_sent = 1'b0;
    cyc(2);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_tx_en", 32'(tx_en), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h3);
    rst_n = 1'b1;
    cyc(1);

    // Single request, sent edge 5 cycles after the start pulse.
    offer(2, 8'h57);
    wait_tx_en("single_start");
    req_valid = '0;
    chk("single_busy", 32'(busy), 32'h1);
    cyc(5);
    tx_sent = 1'b1;
    cyc(1);
    chk("single_gap_busy", 32'(busy), 32'h1);
    chk("single_tx_data_held", 32'(tx_data), 32'h57);
    chk("single_no_timeout", 32'(timeout_err), 32'h0);
    cyc(1);
    chk("single_busy_drop", 32'(busy), 32'h0);
    tx_sent = 1'b0;
    cyc(2);

    // Fresh reset, then all four requesting continuously.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("rr_grant_after_reset", 32'(grant_id), 32'h3);
    offer(0, 8'h41); offer(1, 8'h42); offer(2, 8'h43); offer(3, 8'h44);
    exp_q.push_back('{id: 2'd0, data: 8'h41});
    for (int k = 0; k < 5; k++) begin
      wait_tx_en("rr_start");
      if (k == 4) req_valid = '0;
      complete(2);
    end
    cyc(2);

    // Watchdog with requester 3 pending behind the stuck byte.
    offer(1, 8'h61);
    wait_tx_en("wd_start");
    req_valid = '0;
    offer(3, 8'h63);
    cyc(16);
    chk("wd_not_early", 32'(timeout_err), 32'h0);
    cyc(1);
    chk("wd_fire", 32'(timeout_err), 32'h1);
    chk("wd_busy_gap", 32'(busy), 32'h1);
    cyc(1);
    chk("wd_one_cycle", 32'(timeout_err), 32'h0);
    wait_tx_en("wd_next_start");
    req_valid = '0;
    complete(2);
    cyc(2);

    // Stale sent level through START; only a fresh edge in WAIT completes.
    tx_sent = 1'b1;
    offer(0, 8'h71);
    wait_tx_en("stale_start");
    req_valid = '0;
    cyc(4);
    tx_sent = 1'b0;
    cyc(2);
    chk("stale_ignored_busy", 32'(busy), 32'h1);
    tx_sent = 1'b1;
    cyc(1);
    chk("stale_edge_no_timeout", 32'(timeout_err), 32'h0);
    chk("stale_edge_gap", 32'(busy), 32'h1);
    cyc(1);
    chk("stale_edge_idle", 32'(busy), 32'h0);
    tx_sent = 1'b0;
    cyc(2);

    // Edge lands on the same cycle as the timeout: edge wins.
    offer(1, 8'h72);
    wait_tx_en("coinc_start");
    req_valid = '0;
    cyc(16);
    tx_sent = 1'b1;
    cyc(1);
    chk("coinc_no_timeout", 32'(timeout_err), 32'h0);
    chk("coinc_gap_busy", 32'(busy), 32'h1);
    cyc(1);
    chk("coinc_idle", 32'(busy), 32'h0);
    tx_sent = 1'b0;
    cyc(2);

    // Reset in the middle of WAIT.
    offer(2, 8'h81);
    wait_tx_en("mid_rst_start");
    req_valid = '0;
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'h3);
    chk("mid_rst_tx_data", 32'(tx_data), 32'h0);
    chk("mid_rst_tx_en", 32'(tx_en), 32'h0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    offer(0, 8'h91);
    wait_tx_en("post_rst_start");
    req_valid = '0;
    chk("post_rst_grant_id", 32'(grant_id), 32'h0);
    complete(2);
    cyc(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("timeout_pulse_total", 32'(to_pulses), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
